// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves compare/jump instructions from the ALU result/flag,
//               issues a one-cycle PC redirect + link pulse, then squashes
//               the wrong-path instructions for FLUSH_CYCLES cycles.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_type,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_imm,
  input  logic [PC_W-1:0] alu_c,
  input  logic [1:0]      alu_flag,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            link_valid,
  output logic [PC_W-1:0] link_pc,
  output logic            flush,
  output logic            bad_req
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESP  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [2:0] T_BEQ  = 3'b000;
  localparam logic [2:0] T_BNE  = 3'b001;
  localparam logic [2:0] T_BLT  = 3'b100;
  localparam logic [2:0] T_BGE  = 3'b101;
  localparam logic [2:0] T_JAL  = 3'b010;
  localparam logic [2:0] T_JALR = 3'b011;

  localparam logic [1:0] F_POS  = 2'b00;
  localparam logic [1:0] F_NEG  = 2'b01;
  localparam logic [1:0] F_ZERO = 2'b10;
  localparam logic [1:0] F_BAD  = 2'b11;

  localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [PC_W-1:0] LINK_OFS   = PC_W'(4);
  localparam logic [PC_W-1:0] JALR_MASK  = ~PC_W'(1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            taken_q, taken_d;
  logic            link_q, link_d;
  logic            bad_q, bad_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [PC_W-1:0] link_pc_q, link_pc_d;

  logic            accept;
  logic            dec_branch;
  logic            dec_legal;
  logic            dec_cond;
  logic            dec_link;
  logic            dec_bad;
  logic            dec_taken;
  logic [PC_W-1:0] dec_target;

  assign accept = br_valid && (state_q == S_IDLE);

  // Instruction decode; signed compares rely on the subtraction sign only.
  always_comb begin
    dec_branch = 1'b0;
    dec_legal  = 1'b1;
    dec_cond   = 1'b0;
    dec_link   = 1'b0;
    case (br_type)
      T_BEQ: begin
        dec_branch = 1'b1;
        dec_cond   = (alu_flag == F_ZERO);
      end
      T_BNE: begin
        dec_branch = 1'b1;
        dec_cond   = (alu_flag == F_POS) || (alu_flag == F_NEG);
      end
      T_BLT: begin
        dec_branch = 1'b1;
        dec_cond   = (alu_flag == F_NEG);
      end
      T_BGE: begin
        dec_branch = 1'b1;
        dec_cond   = (alu_flag == F_POS) || (alu_flag == F_ZERO);
      end
      T_JAL, T_JALR: begin
        dec_cond = 1'b1;
        dec_link = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    dec_bad    = !dec_legal || (dec_branch && (alu_flag == F_BAD));
    dec_taken  = dec_cond && !dec_bad;
    dec_target = (br_type == T_JALR) ? (alu_c & JALR_MASK) : (br_pc + br_imm);
  end

  // Request capture: everything RESP presents is frozen at acceptance.
  always_comb begin
    taken_d   = taken_q;
    link_d    = link_q;
    bad_d     = bad_q;
    target_d  = target_q;
    link_pc_d = link_pc_q;
    if (accept) begin
      taken_d   = dec_taken;
      link_d    = dec_link && !dec_bad;
      bad_d     = dec_bad;
      target_d  = dec_target;
      link_pc_d = br_pc + LINK_OFS;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      taken_q   <= 1'b0;
      link_q    <= 1'b0;
      bad_q     <= 1'b0;
      target_q  <= '0;
      link_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      link_q    <= link_d;
      bad_q     <= bad_d;
      target_q  <= target_d;
      link_pc_q <= link_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RESP;
      end
      S_RESP: begin
        if (taken_q && (FLUSH_INIT != 4'd0)) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs decode purely from state so an async reset clears them at once.
  always_comb begin
    br_ready       = (state_q == S_IDLE);
    flush          = (state_q == S_FLUSH);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    link_valid     = 1'b0;
    link_pc        = '0;
    bad_req        = 1'b0;
    if (state_q == S_RESP) begin
      redirect_valid = taken_q;
      redirect_pc    = taken_q ? target_q : '0;
      link_valid     = link_q;
      link_pc        = link_pc_q;
      bad_req        = bad_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed, table-driven bench for branch_resolve_unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk;
  logic        cpu_rst;
  logic        br_valid, br_valid0;
  logic [2:0]  br_type;
  logic [31:0] br_pc, br_imm, alu_c;
  logic [1:0]  alu_flag;

  logic        br_ready, redirect_valid, link_valid, flush, bad_req;
  logic [31:0] redirect_pc, link_pc;
  logic        br_ready0, redirect_valid0, link_valid0, flush0, bad_req0;
  logic [31:0] redirect_pc0, link_pc0;

  int tests = 0;
  int fails = 0;

  branch_resolve_unit #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .br_valid(br_valid), .br_ready(br_ready),
    .br_type(br_type), .br_pc(br_pc), .br_imm(br_imm), .alu_c(alu_c),
    .alu_flag(alu_flag), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_valid(link_valid), .link_pc(link_pc), .flush(flush), .bad_req(bad_req)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(0), .PC_W(32)) dut0 (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .br_valid(br_valid0), .br_ready(br_ready0),
    .br_type(br_type), .br_pc(br_pc), .br_imm(br_imm), .alu_c(alu_c),
    .alu_flag(alu_flag), .redirect_valid(redirect_valid0), .redirect_pc(redirect_pc0),
    .link_valid(link_valid0), .link_pc(link_pc0), .flush(flush0), .bad_req(bad_req0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [1:0]  flag;
    logic        rv;
    logic [31:0] rpc;
    logic        lv;
    logic [31:0] lpc;
    logic        bad;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [2:0] typ, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] alu, input logic [1:0] flag, input logic rv,
                              input logic [31:0] rpc, input logic lv, input logic [31:0] lpc,
                              input logic bad);
    vec_t v;
    v.typ = typ; v.pc = pc; v.imm = imm; v.alu = alu; v.flag = flag;
    v.rv = rv; v.rpc = rpc; v.lv = lv; v.lpc = lpc; v.bad = bad;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!br_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_wait", br_ready, 1'b1);
  endtask

  task automatic drive(input logic [2:0] typ, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] alu, input logic [1:0] flag);
    br_type = typ; br_pc = pc; br_imm = imm; alu_c = alu; alu_flag = flag;
  endtask

  task automatic check_idle_clean(input string tag);
    chk1({tag, "_ready"}, br_ready, 1'b1);
    chk1({tag, "_flush"}, flush, 1'b0);
    chk1({tag, "_rv"}, redirect_valid, 1'b0);
    chk32({tag, "_rpc"}, redirect_pc, 32'h0);
    chk1({tag, "_lv"}, link_valid, 1'b0);
    chk32({tag, "_lpc"}, link_pc, 32'h0);
    chk1({tag, "_bad"}, bad_req, 1'b0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    wait_ready();
    drive(v.typ, v.pc, v.imm, v.alu, v.flag);
    br_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    chk1({t, "_resp_ready"}, br_ready, 1'b0);
    chk1({t, "_rv"}, redirect_valid, v.rv);
    chk32({t, "_rpc"}, redirect_pc, v.rpc);
    chk1({t, "_lv"}, link_valid, v.lv);
    chk32({t, "_lpc"}, link_pc, v.lpc);
    chk1({t, "_bad"}, bad_req, v.bad);
    chk1({t, "_resp_flush"}, flush, 1'b0);
    if (v.rv) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk1({t, "_flush"}, flush, 1'b1);
        chk1({t, "_flush_ready"}, br_ready, 1'b0);
        chk1({t, "_flush_rv"}, redirect_valid, 1'b0);
      end
    end
    @(negedge clk);
    check_idle_clean({t, "_after"});
  endtask

  initial begin
    cpu_rst = 1'b1;
    br_valid = 1'b0;
    br_valid0 = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 32'h0, 2'b00);

    vecs[0]  = mk(3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0, 2'b10, 1'b1, 32'h0000_0120, 1'b0, 32'h0000_0104, 1'b0);
    vecs[1]  = mk(3'b001, 32'h0000_0300, 32'h0000_0040, 32'h0, 2'b10, 1'b0, 32'h0,         1'b0, 32'h0000_0304, 1'b0);
    vecs[2]  = mk(3'b001, 32'h0000_0300, 32'h0000_0040, 32'h0, 2'b01, 1'b1, 32'h0000_0340, 1'b0, 32'h0000_0304, 1'b0);
    vecs[3]  = mk(3'b100, 32'h0000_0400, 32'hFFFF_FFF0, 32'h0, 2'b01, 1'b1, 32'h0000_03F0, 1'b0, 32'h0000_0404, 1'b0);
    vecs[4]  = mk(3'b101, 32'h0000_0400, 32'h0000_0010, 32'h0, 2'b01, 1'b0, 32'h0,         1'b0, 32'h0000_0404, 1'b0);
    vecs[5]  = mk(3'b101, 32'h0000_0400, 32'h0000_0010, 32'h0, 2'b10, 1'b1, 32'h0000_0410, 1'b0, 32'h0000_0404, 1'b0);
    vecs[6]  = mk(3'b011, 32'h0000_0200, 32'h0000_0000, 32'h0000_1235, 2'b11, 1'b1, 32'h0000_1234, 1'b1, 32'h0000_0204, 1'b0);
    vecs[7]  = mk(3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0, 2'b00, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);
    vecs[8]  = mk(3'b000, 32'h0000_0500, 32'h0000_0020, 32'h0, 2'b11, 1'b0, 32'h0,         1'b0, 32'h0000_0504, 1'b1);
    vecs[9]  = mk(3'b111, 32'h0000_0600, 32'h0000_0020, 32'h0, 2'b10, 1'b0, 32'h0,         1'b0, 32'h0000_0604, 1'b1);
    vecs[10] = mk(3'b100, 32'h0000_0700, 32'h0000_0020, 32'h0, 2'b00, 1'b0, 32'h0,         1'b0, 32'h0000_0704, 1'b0);
    vecs[11] = mk(3'b000, 32'h0000_0800, 32'h0000_0020, 32'h0, 2'b00, 1'b0, 32'h0,         1'b0, 32'h0000_0804, 1'b0);

    repeat (2) @(negedge clk);
    check_idle_clean("reset");
    chk1("reset_ready0", br_ready0, 1'b1);
    cpu_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Request held during RESP/FLUSH must wait, then be taken on the first IDLE cycle.
    wait_ready();
    drive(3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0, 2'b10);
    br_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(3'b001, 32'h0000_0900, 32'h0000_0040, 32'h0, 2'b10);
    chk1("hold_resp_rv", redirect_valid, 1'b1);
    chk32("hold_resp_rpc", redirect_pc, 32'h0000_0120);
    @(negedge clk);
    chk1("hold_f1_flush", flush, 1'b1);
    chk1("hold_f1_rv", redirect_valid, 1'b0);
    @(negedge clk);
    chk1("hold_f2_flush", flush, 1'b1);
    @(negedge clk);
    chk1("hold_idle_ready", br_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    chk1("hold_resp2_ready", br_ready, 1'b0);
    chk1("hold_resp2_rv", redirect_valid, 1'b0);
    chk32("hold_resp2_lpc", link_pc, 32'h0000_0904);
    @(negedge clk);
    check_idle_clean("hold_end");

    // Asynchronous reset in the first FLUSH cycle.
    drive(3'b001, 32'h0000_0A00, 32'h0000_0008, 32'h0, 2'b01);
    br_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    chk1("arst_resp_rv", redirect_valid, 1'b1);
    @(negedge clk);
    chk1("arst_pre_flush", flush, 1'b1);
    #2 cpu_rst = 1'b1;
    #1;
    chk1("arst_flush", flush, 1'b0);
    chk1("arst_ready", br_ready, 1'b1);
    @(negedge clk);
    cpu_rst = 1'b0;
    @(negedge clk);
    check_idle_clean("arst_after");

    // FLUSH_CYCLES=0: taken branch goes RESP -> IDLE with no flush.
    drive(3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0, 2'b10);
    br_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    br_valid0 = 1'b0;
    chk1("f0_resp_rv", redirect_valid0, 1'b1);
    chk32("f0_resp_rpc", redirect_pc0, 32'h0000_0120);
    chk1("f0_resp_ready", br_ready0, 1'b0);
    @(negedge clk);
    chk1("f0_ready", br_ready0, 1'b1);
    chk1("f0_flush", flush0, 1'b0);
    chk1("f0_rv_pulse", redirect_valid0, 1'b0);
    chk1("f0_main_untouched", br_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the ALU result and 2-bit flag for compare/jump instructions and decides whether the branch is taken.
- Produces a one-cycle PC redirect pulse and a link address.
- Squashes the following wrong-path instructions for a fixed number of cycles.
- Sits between the execute-stage ALU and the fetch/PC logic, acting as the flag consumer of the ALU interface.

Parameters:
- FLUSH_CYCLES, 2: cycles of flush asserted after a taken branch or jump; legal range 0..15.
- PC_W, 32: width of PC, immediate and ALU result.

Ports:
- cpu_clk  in  1  clock; all state updates on the rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- br_valid  in  1  request present.
- br_ready  out  1  unit can accept a request.
- br_type  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 010 JAL, 011 JALR; other codes illegal.
- br_pc  in  PC_W  PC of the branch instruction.
- br_imm  in  PC_W  sign-extended offset.
- alu_c  in  PC_W  ALU result: rs1-rs2 for compares, rs1+imm for JALR.
- alu_flag  in  2  ALU flag: 00 result>0, 01 result<0 (bit31 set), 10 result==0, 11 invalid.
- redirect_valid  out  1  one-cycle pulse; fetch must load redirect_pc.
- redirect_pc  out  PC_W  target address.
- link_valid  out  1  one-cycle pulse for JAL/JALR.
- link_pc  out  PC_W  br_pc+4.
- flush  out  1  squash the younger instruction this cycle.
- bad_req  out  1  one-cycle pulse for an illegal br_type or alu_flag==11.

Behaviour:
- Reset (async, any state): state IDLE, br_ready=1, all other outputs 0, counter 0.
- States:
  - IDLE: br_ready=1.
  - RESP: one cycle, outputs valid.
  - FLUSH: flush=1, br_ready=0.
- Handshake: accept when br_valid&&br_ready at a clock edge.
  - Inputs are sampled only on that edge; the decision and targets are registered then.
  - br_valid while br_ready=0 is ignored; the requester holds it.
- Latency: decision outputs appear exactly 1 cycle after acceptance (state RESP). br_ready=0 in RESP.
- Taken rules:
  - BEQ: flag==10.
  - BNE: flag==00 or 01.
  - BLT: flag==01.
  - BGE: flag==00 or 10.
  - JAL, JALR: always taken; alu_flag is ignored.
  - BLT/BGE use the sign of the subtraction only; overflow is not corrected. This is the decided behaviour.
- Targets, all PC_W modulo wrap with no overflow detection:
  - Branches and JAL: br_pc+br_imm.
  - JALR: alu_c with bit0 cleared.
- link_pc=br_pc+4 (wraps 0xFFFFFFFC to 0x00000000); link_valid only for JAL/JALR.
- flag==11 on BEQ/BNE/BLT/BGE, or an illegal br_type: not taken, bad_req=1 in RESP, no redirect, no link.
- RESP when taken:
  - redirect_valid=1.
  - Next state FLUSH with counter=FLUSH_CYCLES, or IDLE if FLUSH_CYCLES==0.
- RESP when not taken:
  - redirect_valid=0, redirect_pc=0.
  - Next state IDLE.
- FLUSH: flush=1 each cycle; counter decrements; leave to IDLE when the counter reaches 1→0. Flush therefore lasts exactly FLUSH_CYCLES cycles.
- Pulse outputs (redirect_valid, link_valid, bad_req) are high for exactly one cycle. redirect_pc and link_pc return to 0 outside RESP.
- Back-to-back: a new request can be accepted on the first IDLE cycle, so minimum spacing is 2 cycles when not taken and 2+FLUSH_CYCLES when taken.
- Reset mid-RESP or mid-FLUSH: outputs clear immediately; no pending redirect survives.

Test Plan:
- BEQ, br_pc=0x100, imm=0x20, flag=10 → next cycle redirect_valid=1, redirect_pc=0x120; then flush=1 for 2 cycles; br_ready=1 on cycle 4.
- BNE, flag=10 → redirect_valid=0, flush never asserts, br_ready=1 two cycles after acceptance; BLT flag=01 → taken; BGE flag=01 → not taken.
- JALR, br_pc=0x200, alu_c=0x00001235 → redirect_pc=0x1234, link_valid=1, link_pc=0x204.
- JAL, br_pc=0xFFFFFFFC, imm=8 → redirect_pc=0x4, link_pc=0x0.
- BEQ with flag=11 → bad_req pulse, no redirect; br_type=111 → bad_req, no redirect.
- Assert cpu_rst asynchronously during the first FLUSH cycle → flush drops without waiting for a clock edge, br_ready=1; with FLUSH_CYCLES=0, a taken branch returns to IDLE directly after RESP.
